mem_stack_queue: RTL

Parametrised single-clock memory sequencer that writes ROM-generated words into an internal RAM through an up-counting write pointer and reads them back through either a FIFO pointer or a down-counting LIFO pointer. Each read word is added to the ROM word at the read address and registered with an overflow flag. The block replaces the fixed two-counter ROM/RAM/adder datapath, adding width and depth parameters, full/empty tracking, and a runtime queue/stack mode.

---
 rtl/mem_stack_queue_if.sv | 32 +++
 rtl/mem_stack_queue.sv | 113 +++++++++++
 2 files changed

// File: rtl/mem_stack_queue_if.sv
// Bus bundle for mem_stack_queue: push/pop requests in, pointers/status/read data out.
interface mem_stack_queue_if #(
   parameter int unsigned DATA_W = 8,
   parameter int unsigned ADDR_W = 6
);
   logic              mode;
   logic              en_up;
   logic              en_down;
   logic [ADDR_W-1:0] up_addr;
   logic [ADDR_W-1:0] down_addr;
   logic [DATA_W-1:0] rom_out;
   logic [DATA_W-1:0] ram_out;
   logic [DATA_W-1:0] sum_out;
   logic              sum_ovf;
   logic              rd_valid;
   logic              we_reg;
   logic              full;
   logic              empty;
   logic [ADDR_W:0]   count;

   modport master (
      output mode, en_up, en_down,
      input  up_addr, down_addr, rom_out, ram_out, sum_out, sum_ovf,
             rd_valid, we_reg, full, empty, count
   );

   modport slave (
      input  mode, en_up, en_down,
      output up_addr, down_addr, rom_out, ram_out, sum_out, sum_ovf,
             rd_valid, we_reg, full, empty, count
   );
endinterface

// File: rtl/mem_stack_queue.sv
// mem_stack_queue: RAM filled from a computed ROM through a write pointer and
// drained as a FIFO (read pointer) or LIFO (write pointer counts back down).
// Each popped word is added to ROM(read address) and registered with a carry.
// Optional macro SUM_SAT_EN: saturate sum_out to all ones on carry.
module mem_stack_queue #(
   parameter int unsigned DATA_W = 8,
   parameter int unsigned ADDR_W = 6
) (
   input  logic               clk,
   input  logic               rst_n,
   mem_stack_queue_if.slave   bus
);
   localparam int unsigned DEPTH = 1 << ADDR_W;

   logic [ADDR_W-1:0] r_up_addr;
   logic [ADDR_W-1:0] r_rd_ptr;
   logic [ADDR_W:0]   r_count;
   logic              r_mode_q;
   logic              r_we_reg;
   logic [DATA_W-1:0] r_mem [DEPTH];
   logic [DATA_W-1:0] r_ram_out;
   logic [DATA_W-1:0] r_sum_out;
   logic              r_sum_ovf;
   logic              r_rd_valid;

   logic              w_full;
   logic              w_empty;
   logic              w_pop;
   logic              w_push;
   logic [ADDR_W-1:0] w_down_addr;
   logic [DATA_W-1:0] w_rd_word;
   logic [DATA_W:0]   w_sum_ext;
   logic [DATA_W-1:0] w_sum;

   // ROM(a) = 3a + 1 modulo 2^DATA_W
   function automatic logic [DATA_W-1:0] rom_f(input logic [ADDR_W-1:0] a);
      logic [DATA_W-1:0] v;
      v = DATA_W'(a);
      return (v << 1) + v + DATA_W'(1);
   endfunction

   assign w_full      = (r_count == (ADDR_W+1)'(DEPTH));
   assign w_empty     = (r_count == '0);
   assign w_down_addr = r_mode_q ? (r_up_addr - ADDR_W'(1)) : r_rd_ptr;
   // In stack mode a pop wins over a simultaneous push
   assign w_pop       = bus.en_down && !w_empty;
   assign w_push      = bus.en_up && !w_full && !(r_mode_q && w_pop);

   assign w_rd_word   = r_mem[w_down_addr];
   assign w_sum_ext   = {1'b0, w_rd_word} + {1'b0, rom_f(w_down_addr)};
`ifdef SUM_SAT_EN
   assign w_sum       = w_sum_ext[DATA_W] ? '1 : w_sum_ext[DATA_W-1:0];
`else
   assign w_sum       = w_sum_ext[DATA_W-1:0];
`endif

   // Pointers, occupancy and mode latch
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         r_up_addr <= '0;
         r_rd_ptr  <= '0;
         r_count   <= '0;
         r_mode_q  <= 1'b0;
         r_we_reg  <= 1'b0;
      end else begin
         if (w_empty) r_mode_q <= bus.mode;
         if (r_mode_q) begin
            if (w_pop)       r_up_addr <= r_up_addr - ADDR_W'(1);
            else if (w_push) r_up_addr <= r_up_addr + ADDR_W'(1);
         end else begin
            if (w_push) r_up_addr <= r_up_addr + ADDR_W'(1);
            if (w_pop)  r_rd_ptr  <= r_rd_ptr + ADDR_W'(1);
         end
         if (w_push && !w_pop)      r_count <= r_count + (ADDR_W+1)'(1);
         else if (w_pop && !w_push) r_count <= r_count - (ADDR_W+1)'(1);
         r_we_reg <= w_push;
      end
   end

   // Storage array, not reset; only written entries are ever read
   always_ff @(posedge clk) begin
      if (w_push) r_mem[r_up_addr] <= rom_f(r_up_addr);
   end

   // Registered read word, sum and carry
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         r_ram_out  <= '0;
         r_sum_out  <= '0;
         r_sum_ovf  <= 1'b0;
         r_rd_valid <= 1'b0;
      end else begin
         r_rd_valid <= w_pop;
         if (w_pop) begin
            r_ram_out <= w_rd_word;
            r_sum_out <= w_sum;
            r_sum_ovf <= w_sum_ext[DATA_W];
         end
      end
   end

   assign bus.up_addr   = r_up_addr;
   assign bus.down_addr = w_down_addr;
   assign bus.rom_out   = rom_f(r_up_addr);
   assign bus.ram_out   = r_ram_out;
   assign bus.sum_out   = r_sum_out;
   assign bus.sum_ovf   = r_sum_ovf;
   assign bus.rd_valid  = r_rd_valid;
   assign bus.we_reg    = r_we_reg;
   assign bus.full      = w_full;
   assign bus.empty     = w_empty;
   assign bus.count     = r_count;
endmodule
